// File: rtl/axi_outstanding_limiter_pkg.sv
// Shared constants and types for the outstanding-transaction limiter and its bench.
package axi_track_pkg;

    localparam int DEF_ID_W   = 5;
    localparam int DEF_M_ID_W = 12;

    typedef enum logic {
        RESP_B = 1'b0,
        RESP_R = 1'b1
    } resp_kind_e;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/axi_outstanding_limiter_if.sv
// Handshake/ID bundle between core, limiter and fabric; payloads never pass through here.
interface axi_outstanding_limiter_if
    import axi_track_pkg::*;
#(
    parameter int ID_W   = DEF_ID_W,
    parameter int M_ID_W = DEF_M_ID_W
);
    logic              s_ax_valid;
    logic              s_ax_ready;
    logic [ID_W-1:0]   s_ax_id;
    logic              m_ax_valid;
    logic              m_ax_ready;
    logic [M_ID_W-1:0] m_ax_id;

    logic              s_w_valid;
    logic              s_w_last;
    logic              s_w_ready;
    logic              m_w_valid;
    logic              m_w_ready;

    logic              m_x_valid;
    logic              m_x_last;
    logic              m_x_ready;
    logic [M_ID_W-1:0] m_x_id;
    logic              s_x_valid;
    logic              s_x_ready;
    logic [ID_W-1:0]   s_x_id;

    // The limiter sits on the slave side of this bundle; the environment drives the master side.
    modport slave (
        input  s_ax_valid, s_ax_id, m_ax_ready,
        input  s_w_valid, s_w_last, m_w_ready,
        input  m_x_valid, m_x_last, m_x_id, s_x_ready,
        output s_ax_ready, m_ax_valid, m_ax_id,
        output s_w_ready, m_w_valid,
        output m_x_ready, s_x_valid, s_x_id
    );

    modport master (
        output s_ax_valid, s_ax_id, m_ax_ready,
        output s_w_valid, s_w_last, m_w_ready,
        output m_x_valid, m_x_last, m_x_id, s_x_ready,
        input  s_ax_ready, m_ax_valid, m_ax_id,
        input  s_w_ready, m_w_valid,
        input  m_x_ready, s_x_valid, s_x_id
    );

endinterface

// File: rtl/axi_outstanding_limiter_credit_table.sv
// Per-ID outstanding counters with one increment and one decrement port per cycle.
module axi_id_credit_table
    import axi_track_pkg::*;
#(
    parameter int ID_W       = DEF_ID_W,
    parameter int MAX_PER_ID = 1,
    parameter int CNT_W      = count_width(MAX_PER_ID)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic [ID_W-1:0]  inc_id,
    input  logic             dec,
    input  logic [ID_W-1:0]  dec_id,
    output logic [CNT_W-1:0] inc_count,
    output logic [CNT_W-1:0] dec_count
);
    localparam int DEPTH = 2 ** ID_W;

    logic [DEPTH-1:0][CNT_W-1:0] cnt_all;

    // The caller only increments below MAX_PER_ID and only decrements above zero,
    // so entries cannot wrap.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic             hit_inc;
            logic             hit_dec;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_comb begin
                hit_inc = inc && (inc_id == ID_W'(gi));
                hit_dec = dec && (dec_id == ID_W'(gi));
                cnt_d   = cnt_q;
                if (hit_inc && !hit_dec) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (hit_dec && !hit_inc) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_all[gi] = cnt_q;
        end
    endgenerate

    assign inc_count = cnt_all[inc_id];
    assign dec_count = cnt_all[dec_id];

endmodule

// File: rtl/axi_outstanding_limiter.sv
// Per-ID and global outstanding-transaction limiter for one AXI direction (AW+W+B or AR+R).
module axi_outstanding_limiter
    import axi_track_pkg::*;
#(
    parameter int ID_W       = DEF_ID_W,
    parameter int M_ID_W     = DEF_M_ID_W,
    parameter int MAX_PER_ID = 1,
    parameter int MAX_TOTAL  = 16,
    parameter int HAS_W      = 1,
    parameter int TOT_W      = $clog2(MAX_TOTAL + 1)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      enable,
    input  logic                      clear_err,
    axi_outstanding_limiter_if.slave  bus,
    output logic [TOT_W-1:0]          outstanding,
    output logic                      busy,
    output logic                      err_unexpected,
    output logic [M_ID_W-1:0]         err_id
);
    localparam int CNT_W = count_width(MAX_PER_ID);

    logic [TOT_W-1:0]  outstanding_q;
    logic [TOT_W-1:0]  outstanding_d;
    logic [TOT_W-1:0]  w_pending_q;
    logic [TOT_W-1:0]  w_pending_d;
    logic              err_q;
    logic              err_d;
    logic [M_ID_W-1:0] err_id_q;
    logic [M_ID_W-1:0] err_id_d;

    logic [CNT_W-1:0]  inc_count;
    logic [CNT_W-1:0]  dec_count;
    logic [ID_W-1:0]   x_id_low;
    logic              id_upper_set;
    logic              admit;
    logic              ax_hs;
    logic              w_open;
    logic              w_inc;
    logic              w_done;
    logic              x_hs;
    logic              unexpected;
    logic              complete;

    // Address channel: admit is a pure function of registered state, never of m_ax_ready.
    assign admit = rstn && enable
                && (inc_count < CNT_W'(MAX_PER_ID))
                && (outstanding_q < TOT_W'(MAX_TOTAL));

    assign bus.m_ax_valid = bus.s_ax_valid && admit;
    assign bus.s_ax_ready = bus.m_ax_ready && admit;
    assign bus.m_ax_id    = M_ID_W'(bus.s_ax_id);
    assign ax_hs          = bus.s_ax_valid && bus.m_ax_ready && admit;

    // Write data opens only once its address has been registered as accepted; enable has no say.
    assign w_open        = (HAS_W != 0) && rstn && (w_pending_q != '0);
    assign bus.m_w_valid = bus.s_w_valid && w_open;
    assign bus.s_w_ready = bus.m_w_ready && w_open;
    assign w_inc         = (HAS_W != 0) && ax_hs;
    assign w_done        = bus.s_w_valid && bus.m_w_ready && w_open && bus.s_w_last;

    // Responses always pass; only their bookkeeping is conditional.
    assign bus.s_x_valid = bus.m_x_valid;
    assign bus.m_x_ready = bus.s_x_ready;
    assign x_id_low      = bus.m_x_id[ID_W-1:0];
    assign bus.s_x_id    = x_id_low;
    assign id_upper_set  = (bus.m_x_id >> ID_W) != '0;
    assign x_hs          = bus.m_x_valid && bus.s_x_ready;
    assign unexpected    = x_hs && (id_upper_set || (bus.m_x_last && (dec_count == '0)));
    assign complete      = x_hs && bus.m_x_last && !unexpected;

    axi_id_credit_table #(
        .ID_W       (ID_W),
        .MAX_PER_ID (MAX_PER_ID),
        .CNT_W      (CNT_W)
    ) u_credit (
        .clk        (clk),
        .rstn       (rstn),
        .inc        (ax_hs),
        .inc_id     (bus.s_ax_id),
        .dec        (complete),
        .dec_id     (x_id_low),
        .inc_count  (inc_count),
        .dec_count  (dec_count)
    );

    always_comb begin
        outstanding_d = outstanding_q;
        if (ax_hs && !complete) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (complete && !ax_hs) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        w_pending_d = w_pending_q;
        if (w_inc && !w_done) begin
            w_pending_d = w_pending_q + 1'b1;
        end else if (w_done && !w_inc) begin
            w_pending_d = w_pending_q - 1'b1;
        end

        // A new error beats a simultaneous clear; err_id keeps the first offender.
        err_d    = err_q;
        err_id_d = err_id_q;
        if (unexpected) begin
            err_d = 1'b1;
            if (!err_q) begin
                err_id_d = bus.m_x_id;
            end
        end else if (clear_err) begin
            err_d    = 1'b0;
            err_id_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            outstanding_q <= '0;
            w_pending_q   <= '0;
            err_q         <= 1'b0;
            err_id_q      <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            w_pending_q   <= w_pending_d;
            err_q         <= err_d;
            err_id_q      <= err_id_d;
        end
    end

    assign outstanding    = outstanding_q;
    assign busy           = (outstanding_q != '0);
    assign err_unexpected = err_q;
    assign err_id         = err_id_q;

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Randomised bench: a queue-of-IDs reference model predicts every cycle's outputs; a monitor compares them.
module tb_axi_outstanding_limiter;
    import axi_track_pkg::*;

    localparam int ID_W       = 3;
    localparam int M_ID_W     = 6;
    localparam int MAX_PER_ID = 2;
    localparam int MAX_TOTAL  = 6;
    localparam int TOT_W      = $clog2(MAX_TOTAL + 1);
    localparam int N_IDS      = 2 ** ID_W;
    localparam int N_CYCLES   = 4000;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              enable = 1'b0;
    logic              clear_err = 1'b0;
    logic [TOT_W-1:0]  outstanding;
    logic              busy;
    logic              err_unexpected;
    logic [M_ID_W-1:0] err_id;

    axi_outstanding_limiter_if #(.ID_W(ID_W), .M_ID_W(M_ID_W)) bus ();

    axi_outstanding_limiter #(
        .ID_W       (ID_W),
        .M_ID_W     (M_ID_W),
        .MAX_PER_ID (MAX_PER_ID),
        .MAX_TOTAL  (MAX_TOTAL),
        .HAS_W      (1)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .enable         (enable),
        .clear_err      (clear_err),
        .bus            (bus),
        .outstanding    (outstanding),
        .busy           (busy),
        .err_unexpected (err_unexpected),
        .err_id         (err_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              m_ax_valid;
        logic              s_ax_ready;
        logic [M_ID_W-1:0] m_ax_id;
        logic              m_w_valid;
        logic              s_w_ready;
        logic              s_x_valid;
        logic              m_x_ready;
        logic [ID_W-1:0]   s_x_id;
        logic [TOT_W-1:0]  outstanding;
        logic              busy;
        logic              err;
        logic [M_ID_W-1:0] err_id;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: every accepted-but-uncompleted transaction is one entry holding its ID.
    int   open_ids[$];
    int   wpend = 0;
    bit   m_err = 1'b0;
    int   m_err_id = 0;
    resp_kind_e kind = RESP_R;

    function automatic int cnt_of(input int id);
        int n = 0;
        foreach (open_ids[i]) if (open_ids[i] == id) n++;
        return n;
    endfunction

    function automatic bit model_admit();
        return rstn && enable
            && (cnt_of(int'(bus.s_ax_id)) < MAX_PER_ID)
            && (open_ids.size() < MAX_TOTAL);
    endfunction

    // Apply the clock edge that just happened, using the inputs held during the previous cycle.
    task automatic model_step(input int cyc);
        bit ax_hs, w_done, x_hs, bad;
        int low, upper;
        if (!rstn) begin
            open_ids.delete();
            wpend    = 0;
            m_err    = 1'b0;
            m_err_id = 0;
            return;
        end
        ax_hs  = bus.s_ax_valid && bus.m_ax_ready && model_admit();
        w_done = bus.s_w_valid && bus.m_w_ready && (wpend > 0) && bus.s_w_last;
        x_hs   = bus.m_x_valid && bus.s_x_ready;
        low    = int'(bus.m_x_id[ID_W-1:0]);
        upper  = int'(bus.m_x_id) >> ID_W;
        bad    = x_hs && ((upper != 0) || (bus.m_x_last && cnt_of(low) == 0));
        if (bad) begin
            if (!m_err) m_err_id = int'(bus.m_x_id);
            m_err = 1'b1;
            $display("cyc %0d: unexpected response id=0x%0h", cyc, bus.m_x_id);
        end else if (clear_err) begin
            m_err    = 1'b0;
            m_err_id = 0;
        end
        if (x_hs && bus.m_x_last && !bad) begin
            for (int i = 0; i < open_ids.size(); i++) begin
                if (open_ids[i] == low) begin
                    open_ids.delete(i);
                    break;
                end
            end
            $display("cyc %0d: complete id=%0d outstanding=%0d", cyc, low, open_ids.size());
        end
        if (ax_hs) begin
            open_ids.push_back(int'(bus.s_ax_id));
            wpend++;
            $display("cyc %0d: accept id=%0d outstanding=%0d", cyc, bus.s_ax_id, open_ids.size());
        end
        if (w_done) wpend--;
    endtask

    task automatic drive(input int cyc);
        bit fill;
        int rate, start, cand;
        rstn      = !(cyc < 3 || (cyc >= 2000 && cyc < 2003));
        enable    = (cyc >= 900 && cyc < 1200) ? 1'b0 : ($urandom_range(0, 19) != 0);
        clear_err = ($urandom_range(0, 29) == 0);
        kind      = (cyc < 2500) ? RESP_R : RESP_B;
        fill      = (cyc >= 300 && cyc < 600);

        bus.s_ax_valid = ($urandom_range(0, 9) < 6);
        bus.s_ax_id    = ID_W'($urandom_range(0, N_IDS - 1));
        bus.m_ax_ready = ($urandom_range(0, 9) < 7);
        bus.s_w_valid  = ($urandom_range(0, 9) < 6);
        bus.s_w_last   = ($urandom_range(0, 9) < 4);
        bus.m_w_ready  = ($urandom_range(0, 9) < 7);
        bus.s_x_ready  = ($urandom_range(0, 9) < 7);

        bus.m_x_valid = 1'b0;
        bus.m_x_id    = '0;
        bus.m_x_last  = 1'b0;
        rate = fill ? 5 : 40;
        if ($urandom_range(0, 99) < rate) begin
            if (open_ids.size() > 0 && $urandom_range(0, 9) != 0) begin
                // A legitimate completion needs a transaction whose write data has already gone.
                bus.m_x_valid = 1'b1;
                bus.m_x_id    = M_ID_W'(open_ids[$urandom_range(0, open_ids.size() - 1)]);
                bus.m_x_last  = (kind == RESP_B) ? 1'b1 : ($urandom_range(0, 2) != 0);
                if (wpend >= open_ids.size()) begin
                    if (kind == RESP_B) bus.m_x_valid = 1'b0;
                    bus.m_x_last = 1'b0;
                end
            end else if ($urandom_range(0, 1) == 1) begin
                bus.m_x_valid = 1'b1;
                bus.m_x_id    = {3'($urandom_range(1, 7)), 3'($urandom_range(0, 7))};
                bus.m_x_last  = 1'b1;
            end else begin
                start = $urandom_range(0, N_IDS - 1);
                for (int k = 0; k < N_IDS; k++) begin
                    cand = (start + k) % N_IDS;
                    if (cnt_of(cand) == 0) begin
                        bus.m_x_valid = 1'b1;
                        bus.m_x_id    = M_ID_W'(cand);
                        bus.m_x_last  = (kind == RESP_B) ? 1'b1 : ($urandom_range(0, 1) == 1);
                        break;
                    end
                end
            end
        end
    endtask

    function automatic obs_t predict();
        obs_t e;
        bit   admit, wopen;
        admit         = model_admit();
        wopen         = rstn && (wpend > 0);
        e.m_ax_valid  = bus.s_ax_valid && admit;
        e.s_ax_ready  = bus.m_ax_ready && admit;
        e.m_ax_id     = M_ID_W'(bus.s_ax_id);
        e.m_w_valid   = bus.s_w_valid && wopen;
        e.s_w_ready   = bus.m_w_ready && wopen;
        e.s_x_valid   = bus.m_x_valid;
        e.m_x_ready   = bus.s_x_ready;
        e.s_x_id      = bus.m_x_id[ID_W-1:0];
        e.outstanding = TOT_W'(open_ids.size());
        e.busy        = (open_ids.size() != 0);
        e.err         = m_err;
        e.err_id      = M_ID_W'(m_err_id);
        return e;
    endfunction

    initial begin
        bus.s_ax_valid = 1'b0;
        bus.s_ax_id    = '0;
        bus.m_ax_ready = 1'b0;
        bus.s_w_valid  = 1'b0;
        bus.s_w_last   = 1'b0;
        bus.m_w_ready  = 1'b0;
        bus.m_x_valid  = 1'b0;
        bus.m_x_last   = 1'b0;
        bus.m_x_id     = '0;
        bus.s_x_ready  = 1'b0;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            model_step(cyc);
            drive(cyc);
            exp_q.push_back(predict());
        end

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{m_ax_valid: bus.m_ax_valid, s_ax_ready: bus.s_ax_ready, m_ax_id: bus.m_ax_id,
                      m_w_valid: bus.m_w_valid, s_w_ready: bus.s_w_ready, s_x_valid: bus.s_x_valid,
                      m_x_ready: bus.m_x_ready, s_x_id: bus.s_x_id, outstanding: outstanding,
                      busy: busy, err: err_unexpected, err_id: err_id};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_outputs t=%0t actual: axv=%b axr=%b axid=%h wv=%b wr=%b xv=%b xr=%b xid=%h out=%0d busy=%b err=%b eid=%h required: axv=%b axr=%b axid=%h wv=%b wr=%b xv=%b xr=%b xid=%h out=%0d busy=%b err=%b eid=%h",
                             $time, a.m_ax_valid, a.s_ax_ready, a.m_ax_id, a.m_w_valid, a.s_w_ready,
                             a.s_x_valid, a.m_x_ready, a.s_x_id, a.outstanding, a.busy, a.err, a.err_id,
                             e.m_ax_valid, e.s_ax_ready, e.m_ax_id, e.m_w_valid, e.s_w_ready,
                             e.s_x_valid, e.m_x_ready, e.s_x_id, e.outstanding, e.busy, e.err, e.err_id);
                end
            end
        end
    end

endmodule

// File: doc/axi_outstanding_limiter.md
# axi_outstanding_limiter

Parametrised per-ID outstanding-transaction limiter inserted between a core-side AXI master (slave port, `s_*`) and the host AXI-MM fabric (master port, `m_*`). One instance handles one direction: AW+W+B or AR+R.

- Admission is bounded by a per-ID credit limit and a global outstanding limit.
- Write data is released only for addresses already accepted.
- Deasserting `enable` drains in-flight traffic instead of freezing it.
- Address/data payloads bypass the block; only handshakes and IDs pass through.

## Interface
Parameters:
- ID_W, 5: significant ID bits tracked (2**ID_W table entries).
- M_ID_W, 12: fabric ID width; upper bits driven 0.
- MAX_PER_ID, 1: maximum outstanding transactions per ID (1 reproduces single-bit lock behaviour).
- MAX_TOTAL, 16: maximum outstanding transactions across all IDs.
- HAS_W, 1: 1 for a write instance (W gating active); 0 ties m_w_valid/s_w_ready to 0.
- TOT_W, $clog2(MAX_TOTAL+1): width of the outstanding count.

Ports (reset rstn, synchronous, active-low; clock clk):
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- enable  in  1  admit new addresses when 1; responses always flow
- clear_err  in  1  clears err_unexpected/err_id
- s_ax_valid / s_ax_ready  in/out  1  core address handshake
- s_ax_id  in  ID_W  core address ID
- m_ax_valid / m_ax_ready  out/in  1  fabric address handshake
- m_ax_id  out  M_ID_W  {0, s_ax_id}
- s_w_valid, s_w_last / s_w_ready  in/out  1  core write data
- m_w_valid / m_w_ready  out/in  1  fabric write data
- m_x_valid, m_x_last / m_x_ready  in/out  1  fabric response (B: tie last=1; R: rlast)
- m_x_id  in  M_ID_W  fabric response ID
- s_x_valid / s_x_ready  out/in  1  core response handshake
- s_x_id  out  ID_W  m_x_id[ID_W-1:0]
- outstanding  out  TOT_W  total accepted, not yet completed
- busy  out  1  outstanding != 0
- err_unexpected  out  1  sticky: response for untracked ID
- err_id  out  M_ID_W  ID of first unexpected response

## Operation
- Admission: `admit = enable && cnt[s_ax_id] < MAX_PER_ID && outstanding < MAX_TOTAL`.
  - m_ax_valid = s_ax_valid && admit.
  - s_ax_ready = m_ax_ready && admit.
  - admit never depends on m_ax_ready.
- Address handshake (m_ax_valid && m_ax_ready):
  - cnt[id]++ and outstanding++.
  - If HAS_W: w_pending++.
- W gating: m_w_valid = s_w_valid && w_pending != 0; s_w_ready = m_w_ready && w_pending != 0. A W handshake with s_w_last decrements w_pending.
  - W is not gated by enable, so data for accepted addresses always completes.
- Response: s_x_valid = m_x_valid; m_x_ready = s_x_ready; passthrough regardless of enable.
  - A handshake with m_x_last completes a transaction: cnt[id]-- and outstanding--.
  - Non-last R beats change nothing.
- Unexpected response (upper ID bits nonzero, or cnt[id]==0 on a completing beat):
  - Still passed through.
  - Counters unchanged.
  - err_unexpected set; err_id captured only if err_unexpected was 0.
- Same-cycle events:
  - Accept and complete on the same ID: cnt unchanged; outstanding unchanged.
  - Accept and complete on different IDs: each counter updated independently.
  - AW accept and W last in the same cycle: w_pending unchanged.
  - clear_err together with a new error: the error wins (set).
- Drain: enable 0 blocks admission only; busy falls once all responses return.

## Timing
- All forwarding paths are combinational; zero added latency; no payload registers.
- State updates at the posedge after a handshake; admit reflects updated counters the next cycle.
  - With MAX_PER_ID=1, a same-ID reissue is accepted at the earliest one cycle after its completing response.
- W for an address is blocked in the cycle of its AW handshake (w_pending still 0) and released the next cycle.
- Reset values: all cnt=0, outstanding=0, w_pending=0, busy=0, err_unexpected=0, err_id=0.
  - m_ax_valid=0 and m_w_valid=0 whenever rstn=0.
- Reset mid-operation: all tracking is discarded. Responses arriving after reset flag err_unexpected. Software must quiesce the fabric before asserting reset.
- Widths: cnt entries are $clog2(MAX_PER_ID+1) bits; w_pending is TOT_W bits. Counters saturate by construction and never wrap.

## Structure
- Package axi_track_pkg: default ID_W/M_ID_W constants and the response-kind enum (RESP_B, RESP_R), used by the bench.
- Sub-module axi_id_credit_table holds the 2**ID_W counter array.
  - Inputs: inc, inc_id, dec, dec_id.
  - Outputs: count at inc_id and count at dec_id.
- The top level holds the outstanding count, w_pending, the error capture and the handshake gating.

## Test plan
- MAX_PER_ID=1: AW id 3 accepted; second AW id 3 stalls (s_ax_ready=0) until B id 3 handshakes; accepted the following cycle; AW id 4 passes meanwhile.
- MAX_PER_ID=4, MAX_TOTAL=6: issue 4×id1 and 2×id2 → outstanding=6; a 7th AW stalls; one R beat with last=0 changes nothing; rlast frees one slot.
- W gating: W presented 3 cycles before its AW → m_w_valid=0 throughout. AW handshake at cycle t → W forwarded from t+1. Two AWs back-to-back → two last-terminated bursts pass, then W blocks.
- Drain: 5 outstanding, enable→0; new AR stalls; 5 responses pass; busy falls the cycle after the 5th completes.
- Unexpected: B with id 0x21 (upper bits set) or for an idle id 7 → forwarded, err_unexpected=1, err_id=0x21; a later error leaves err_id unchanged; clear_err clears both.
- Simultaneous: accept id 2 and complete id 2 in the same cycle → outstanding unchanged; rstn pulse mid-burst → all counters 0 and m_ax_valid=0 during reset.
